alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU for the MIPS datapath: WIDTH-bit operands, single-cycle logic/shift/compare ops

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq_muldiv.sv | 97 +++++++++
 rtl/alu_seq.sv | 87 ++++++++
 tb/tb_alu_seq.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and op classification for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    // MULT/MULTU/DIV/DIVU occupy 10xx; op[1] selects divide, op[0] selects unsigned.
    function automatic logic is_multi(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the EX stage and the sequential ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] HI;

    modport master (
        output in_valid, ALUOp, A, B, out_ready,
        input  in_ready, out_valid, C, HI
    );

    modport slave (
        input  in_valid, ALUOp, A, B, out_ready,
        output in_ready, out_valid, C, HI
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative multiply/divide core: one bit per cycle on operand magnitudes, sign fix-up on the way out.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_hi, r_lo, r_m, r_a;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_div, r_a_neg, r_b_neg, r_div0;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_iter_hi, w_iter_lo;
    logic [WIDTH:0]     w_sum, w_rsh, w_diff;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_neg = ~i_op[0] & i_a[WIDTH-1];
    assign w_b_neg = ~i_op[0] & i_b[WIDTH-1];
    // |MIN| fits as an unsigned WIDTH-bit value, so no extra magnitude bit is needed.
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;
    assign o_last  = (r_state == StCalc) && (r_cnt == SHAMT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StCalc;
            StCalc:  if (o_last) w_state_next = StFix;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_m     <= w_b_mag;
            r_a     <= i_a;
            r_cnt   <= '0;
            r_div   <= i_op[1];
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_div0  <= (i_b == '0);
        end else if (r_state == StCalc) begin
            r_hi  <= w_iter_hi;
            r_lo  <= w_iter_lo;
            r_cnt <= r_cnt + SHAMT_W'(1);
        end
    end

    // Multiply: shift-add from the LSB of r_lo. Divide: restoring, quotient shifts into r_lo.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_rsh  = {r_hi, r_lo[WIDTH-1]};
        w_diff = w_rsh - {1'b0, r_m};
        if (!r_div) begin
            w_iter_hi = w_sum[WIDTH:1];
            w_iter_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            w_iter_hi = w_diff[WIDTH-1:0];
            w_iter_lo = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_iter_hi = w_rsh[WIDTH-1:0];
            w_iter_lo = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        w_prod = {r_hi, r_lo};
        if (!r_div) begin
            {o_hi, o_lo} = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
        end else if (r_div0) begin
            o_lo = '1;
            o_hi = r_a;
        end else begin
            o_lo = (r_a_neg ^ r_b_neg) ? -r_lo : r_lo;
            o_hi = r_a_neg ? -r_hi : r_hi;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops and result registers around the mul/div core.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_c, r_hi;
    logic               w_accept, w_multi, w_core_last;
    logic [SHAMT_W-1:0] w_sh;
    logic [WIDTH-1:0]   w_single, w_core_lo, w_core_hi;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_multi  = is_multi(bus.ALUOp);
    assign w_sh     = bus.B[SHAMT_W-1:0];

    alu_seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_accept & w_multi),
        .i_op   (bus.ALUOp[1:0]),
        .i_a    (bus.A),
        .i_b    (bus.B),
        .o_last (w_core_last),
        .o_lo   (w_core_lo),
        .o_hi   (w_core_hi)
    );

    always_comb begin
        w_single = '0;
        case (bus.ALUOp)
            ALU_ADD: w_single = bus.A + bus.B;
            ALU_SUB: w_single = bus.A - bus.B;
            ALU_AND: w_single = bus.A & bus.B;
            ALU_OR:  w_single = bus.A | bus.B;
            ALU_SRL: w_single = bus.A >> w_sh;
            ALU_SRA: w_single = $signed(bus.A) >>> w_sh;
            ALU_SLL: w_single = bus.A << w_sh;
            ALU_SLT: w_single = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            default: w_single = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = w_multi ? StCalc : StDone;
            StCalc: if (w_core_last) w_state_next = StFix;
            StFix:  w_state_next = StDone;
            StDone: if (bus.out_ready) w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == StIdle);
        bus.out_valid = (r_state == StDone);
        bus.C         = r_c;
        bus.HI        = r_hi;
    end

    // Results only load at accept or on leaving FIX, so they stay stable while DONE waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c  <= '0;
            r_hi <= '0;
        end else if (w_accept && !w_multi) begin
            r_c  <= w_single;
            r_hi <= '0;
        end else if (r_state == StFix) begin
            r_c  <= w_core_lo;
            r_hi <= w_core_hi;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at issue, compared when the result is taken.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] c;
        logic [31:0] hi;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] hi;
    } vec_t;

    exp_t sb_q[$];

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic int exp_lat(input logic [3:0] op);
        return (op[3:2] == 2'b10) ? 34 : 1;
    endfunction

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic [31:0] hi);
        logic [63:0] p;
        logic [4:0]  sh;
        sh = b[4:0];
        c  = '0;
        hi = '0;
        p  = '0;
        case (op)
            4'b0000: c = a + b;
            4'b0001: c = a - b;
            4'b0010: c = a & b;
            4'b0011: c = a | b;
            4'b0100: c = a >> sh;
            4'b0101: c = $signed(a) >>> sh;
            4'b0110: c = a << sh;
            4'b0111: c = {31'b0, $signed(a) < $signed(b)};
            4'b1000: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {hi, c} = p;
            end
            4'b1001: begin
                p = {32'b0, a} * {32'b0, b};
                {hi, c} = p;
            end
            4'b1010: begin
                if (b == 32'd0) begin
                    c  = '1;
                    hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    c  = a;
                    hi = '0;
                end else begin
                    c  = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            4'b1011: begin
                if (b == 32'd0) begin
                    c  = '1;
                    hi = a;
                end else begin
                    c  = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one op, wait (bounded) for the result, sample it, then consume it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] c, output logic [31:0] hi, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.ALUOp    = op;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.B        = $urandom;
        bus.ALUOp    = 4'($urandom_range(0, 15));
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        c  = bus.C;
        hi = bus.HI;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        n_tests++;
        if ({bus.C, bus.HI} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: C=%h HI=%h, expected 0/0", bus.C, bus.HI);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_out_ready_ignored: out_valid=%b in_ready=%b, expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_vectors(input string name, input vec_t v[]);
        logic [31:0] c, hi;
        int          lat;
        exp_t        e;
        foreach (v[i]) begin
            sb_q.push_back('{c: v[i].c, hi: v[i].hi, lat: exp_lat(v[i].op)});
            run_op(v[i].op, v[i].a, v[i].b, c, hi, lat);
            e = sb_q.pop_front();
            n_tests++;
            if ({c, hi} !== {e.c, e.hi} || lat != e.lat) begin
                n_fail++;
                $display("FAIL %s[%0d] op=%h: C=%h HI=%h lat=%0d, expected C=%h HI=%h lat=%0d",
                         name, i, v[i].op, c, hi, lat, e.c, e.hi, e.lat);
            end
        end
    endtask

    task automatic test_single();
        vec_t v[];
        v = new[9];
        v[0] = '{4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0};
        v[1] = '{4'h1, 32'h0,         32'h1,         32'hFFFF_FFFF, 32'h0};
        v[2] = '{4'h5, 32'h8000_00F0, 32'h24,        32'hF800_000F, 32'h0};
        v[3] = '{4'h4, 32'h8000_00F0, 32'h24,        32'h0800_000F, 32'h0};
        v[4] = '{4'h7, 32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0};
        v[5] = '{4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0};
        v[6] = '{4'h3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'h0};
        v[7] = '{4'h6, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 32'h0};
        v[8] = '{4'hC, 32'h0000_0005, 32'h0000_0003, 32'h0,         32'h0};
        test_vectors("single", v);
    endtask

    task automatic test_muldiv();
        vec_t v[];
        v = new[7];
        v[0] = '{4'h8, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 32'hFFFF_FFFF};
        v[1] = '{4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        v[2] = '{4'hA, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        v[3] = '{4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        v[4] = '{4'hB, 32'h5,         32'h0,         32'hFFFF_FFFF, 32'h5};
        v[5] = '{4'hA, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFF9};
        v[6] = '{4'hB, 32'd100,       32'd7,         32'd14,        32'd2};
        test_vectors("muldiv", v);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   guard;
        sb_q.push_back('{c: 32'd7, hi: 32'd0, lat: 1});
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALUOp    = 4'h0;
        bus.A        = 32'd3;
        bus.B        = 32'd4;
        @(posedge clk);
        #1;
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.ALUOp    = 4'h1;
            bus.A        = $urandom;
            bus.B        = $urandom;
            @(posedge clk);
            #1;
            n_tests++;
            if ({bus.C, bus.HI} !== {e.c, e.hi} || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            begin
                n_fail++;
                $display("FAIL stall[%0d]: C=%h HI=%h in_ready=%b out_valid=%b, expected C=%h HI=%h 0/1",
                         k, bus.C, bus.HI, bus.in_ready, bus.out_valid, e.c, e.hi);
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: in_ready=%b out_valid=%b, expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.C !== e.c) begin
            n_fail++;
            $display("FAIL stalled_request_dropped: out_valid=%b C=%h, expected 0 C=%h",
                     bus.out_valid, bus.C, e.c);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c, hi;
        int          lat;
        exp_t        e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALUOp    = 4'h8;
        bus.A        = 32'hFFFF_FFFD;
        bus.B        = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {bus.C, bus.HI} !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b C=%h HI=%h, expected 0/1 0/0",
                     bus.out_valid, bus.in_ready, bus.C, bus.HI);
        end
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back('{c: 32'd4, hi: 32'd0, lat: 1});
        run_op(4'h0, 32'd2, 32'd2, c, hi, lat);
        e = sb_q.pop_front();
        n_tests++;
        if ({c, hi} !== {e.c, e.hi} || lat != e.lat) begin
            n_fail++;
            $display("FAIL after_reset_add: C=%h HI=%h lat=%0d, expected C=%h HI=%h lat=%0d",
                     c, hi, lat, e.c, e.hi, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, hi, ec, ehi;
        logic [3:0]  op;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 12; i++) begin
            op = (i % 2 == 0) ? 4'(8 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = -b;
            model(op, a, b, ec, ehi);
            sb_q.push_back('{c: ec, hi: ehi, lat: exp_lat(op)});
            run_op(op, a, b, c, hi, lat);
            e = sb_q.pop_front();
            n_tests++;
            if ({c, hi} !== {e.c, e.hi} || lat != e.lat) begin
                n_fail++;
                $display("FAIL b2b[%0d] op=%h A=%h B=%h: C=%h HI=%h lat=%0d, expected C=%h HI=%h lat=%0d",
                         i, op, a, b, c, hi, lat, e.c, e.hi, e.lat);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ALUOp     = 4'h0;
        bus.A         = '0;
        bus.B         = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_muldiv();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
